// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A single full-adder cell (two cascaded half
// adders plus an OR) is reused once per clock, LSB first, with the carry
// closed through a flip-flop. An accepted start captures the operands. After
// WIDTH processing cycles, sum/cout/ovf are loaded and done pulses for one
// cycle.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' port is added. With sub=1 the B operand is loaded
//   inverted and the carry is forced to 1, so the result is a - b and
//   cout=1 means "no borrow".
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy=0
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout/ovf have just been updated
//   sum    out  registered WIDTH-bit result, held between operations
//   cout   out  registered carry out of the MSB
//   ovf    out  registered signed overflow (carry into MSB ^ carry out)
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        half_add = {x & y, x ^ y};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       ha1_s, ha2_s;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic [WIDTH-1:0] s_shift_s;

    // Full-adder cell on the current LSBs and the carry flop.
    always_comb begin
        ha1_s     = half_add(a_sr_q[0], b_sr_q[0]);
        ha2_s     = half_add(ha1_s[0], c_q);
        bit_s     = ha2_s[0];
        bit_c     = ha1_s[1] | ha2_s[1];
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
        s_shift_s = {bit_s, s_sr_q[WIDTH-1:1]};
    end

    // Operand B / carry values loaded on an accepted start.
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            // a - b = a + ~b + 1; cin is ignored.
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b_load_s;
                    c_d     = c_load_s;
                    s_sr_d  = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d = s_shift_s;
                c_d    = bit_c;
                if (cnt_q == CNT_LAST) begin
                    // MSB step: c_q is still the carry into the MSB here.
                    cnt_d   = {CW{1'b0}};
                    sum_d   = s_shift_s;
                    cout_d  = bit_c;
                    ovf_d   = c_q ^ bit_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            s_sr_q  <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder: table-driven vectors plus hand-written sequences
// (back-to-back starts, reset abort). Expected results go into a scoreboard
// queue when a start is driven and are compared when done pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic         sub_s = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_s),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer add; ovf from operand/result signs.
    function automatic vec_t mk(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic icin, input logic isub);
        vec_t         v;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        bb   = isub ? ~ib : ib;
        cc   = isub ? 1'b1 : icin;
        full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, cc};
        v.a   = ia;
        v.b   = ib;
        v.cin = icin;
        v.sub = isub;
        v.es  = full[W-1:0];
        v.ec  = full[W];
        v.eo  = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
        return v;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: done=1 with no pending operation (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum",  sum,  e.sum);
                check("cout", cout, e.cout);
                check("ovf",  ovf,  e.ovf);
            end
        end
    end

    // One operation with timing checks on busy/done.
    task automatic run_op(input vec_t v);
        exp_t e;
        @(negedge clk);
        check("idle_before_start", busy, 1'b0);
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        sub_s = v.sub;
        start = 1'b1;
        e.sum  = v.es;
        e.cout = v.ec;
        e.ovf  = v.eo;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Operands are free to change once captured.
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        sub_s = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            check("busy_run", {done, busy}, 2'b01);
        end
        @(negedge clk);
        check("done_cycle", {done, busy}, 2'b10);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() > 0; k++) @(negedge clk);
        check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int last_done;
        int n_done;
        int seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy_done", {busy, done}, 2'b00);
        check("reset_sum_cout_ovf", {sum, cout, ovf}, 0);
        rst_n = 1'b1;

        // Vector table
        vecs.push_back('{4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0});
        vecs.push_back('{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1});
        vecs.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0});
        vecs.push_back('{4'b1000, 4'b0001, 1'b1, 1'b1, 4'b0111, 1'b1, 1'b1});
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
`endif
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b0));

        foreach (vecs[i]) run_op(vecs[i]);
        drain();

        // Back-to-back: start held high, operands scrambled while busy
        @(negedge clk);
        last_done = -1;
        n_done    = 0;
        start     = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (done) begin
                if (last_done >= 0) check("b2b_gap", i - last_done, W + 1);
                last_done = i;
                n_done++;
            end
            if (!busy) begin
                exp_t e;
                a = 4'b0001; b = 4'b0001; cin = 1'b0; sub_s = 1'b0;
                e.sum = 4'b0010; e.cout = 1'b0; e.ovf = 1'b0;
                sb_q.push_back(e);
            end else begin
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub_s = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", n_done, 4);
        drain();

        // Reset abort two cycles after an accepted start
        @(negedge clk);
        a = 4'b0111; b = 4'b0111; cin = 1'b1; sub_s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_started", busy, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy_done", {busy, done}, 2'b00);
        check("abort_sum", sum, 0);
        check("abort_cout_ovf", {cout, ovf}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);

        // Normal operation after the abort
        run_op(mk(4'b0110, 4'b0111, 1'b0, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single registered full-adder cell: one half-adder pair plus a carry flip-flop, reused once per clock. It accepts two WIDTH-bit operands on a start pulse and processes them LSB-first, one bit per cycle. It then presents the registered sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequential stage directly downstream of the combinational half-adder: it consumes the half-adder sum/carry pair each cycle and closes the carry loop through a register.

## Interface
- WIDTH, 4, operand/sum width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A, captured on the accepted start edge.
- b  in  WIDTH  operand B, captured on the accepted start edge.
- cin  in  1  carry-in, captured on the accepted start edge.
- sub  in  1  subtract select. Present only with SERIAL_ADDER_SUB_EN.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse: sum/cout/ovf were just updated.
- sum  out  WIDTH  registered result; held between operations.
- cout  out  1  registered carry out of the MSB.
- ovf  out  1  registered signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE or DONE with start=1:
  - Latch a into shift register A and b into shift register B.
  - Load the carry flip-flop with cin.
  - Clear bit counter and sum shift register.
  - Go to RUN.
- IDLE or DONE with start=0: go to / stay in IDLE.
- RUN, each cycle:
  - s = A[0]^B[0]^c; c_next = A[0]&B[0] | c&(A[0]^B[0]), formed as two cascaded half adders plus OR.
  - s shifts into the sum shift register MSB. A and B shift right.
  - Counter increments. Before updating c on the MSB bit, the carry into the MSB is captured for ovf.
  - When the counter reaches WIDTH-1 (the MSB is processed on this edge), go to DONE.
- DONE, entry edge: sum, cout and ovf load from the internal registers. They hold until the next DONE entry.
- start while in RUN is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry; ovf is two's-complement overflow.
- Counter width: clog2(WIDTH).

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, counter 0, carry 0.
- Reset is asynchronous. Assertion mid-RUN aborts the operation immediately: no done pulse, and outputs return to reset values.
- Accepted start at edge E0 gives busy=1 from E0 to E_WIDTH.
- done=1 and the new sum/cout/ovf are visible for exactly one cycle after edge E_WIDTH.
- Latency: WIDTH cycles from start acceptance to done.
- busy=0 during the done cycle. start may be asserted in that cycle and is accepted at the next edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- done never asserts without a preceding accepted start.
- Operands may change freely after the accepted start edge.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Port sub exists and is captured with the operands.
  - sub=1: B loads ~b and the carry loads 1, so cin is ignored. The result is a-b, and cout=1 means no borrow.
  - sub=0: identical to the undefined build.
- SERIAL_ADDER_SUB_EN undefined: no sub port; addition only.

## Test plan
- WIDTH=4, a=0101, b=0011, cin=0, start one cycle → busy for 4 cycles, then done=1 for 1 cycle with sum=1000, cout=0, ovf=1.
- a=1111, b=0001, cin=0 → sum=0000, cout=1, ovf=0. With a=0000, b=0000, cin=1 → sum=0001, cout=0.
- start held high continuously with a=0001, b=0001 → a result every 5 cycles, sum=0010 each time. Operands changed mid-RUN do not affect the in-flight result.
- rst_n pulsed low 2 cycles after an accepted start → busy/done/sum/cout/ovf all 0 immediately, and no done pulse follows. The next start completes normally.
- With SERIAL_ADDER_SUB_EN: a=0011, b=0101, sub=1 → sum=1110, cout=0, ovf=0. a=1000, b=0001, sub=1 → sum=0111, cout=1, ovf=1.
